cpu_mem_bridge: RTL and testbench
=================================

CPU_MEM_BRIDGE -- requirements
Module: cpu_mem_bridge

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles to wait for mem_ack before aborting an access (range 1..255).
REQ-002 The block SHALL have parameter ERR_DATA, default 8'hFF, meaning the read data returned on a timed-out access.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 ab  input  16  CPU address, valid every cycle rdy=1.
REQ-006 we  input  1  CPU write enable, qualifies ab/dout.
REQ-007 dout  input  8  CPU write data.
REQ-008 din  output  8  read data to CPU, registered.
REQ-009 rdy  output  1  CPU ready; 0 freezes the CPU.
REQ-010 mem_req  output  1  backend request, registered.
REQ-011 mem_addr  output  16  backend address.
REQ-012 mem_we  output  1  backend write strobe.
REQ-013 mem_wdata  output  8  backend write data.
REQ-014 mem_ack  input  1  backend completion, single-cycle pulse.
REQ-015 mem_rdata  input  8  backend read data, valid with mem_ack.
REQ-016 bus_err  output  1  one-cycle pulse on timeout.
REQ-017 stall_cnt  output  32  count of cycles with rdy=0.
REQ-018 acc_cnt  output  32  count of completed accesses (acked or timed out).

Function
REQ-019 FSM states SHALL be IDLE, WAIT, DONE.
REQ-020 In IDLE, rdy=1 and the access on ab/we/dout SHALL be captured at the rising edge, with a transition to WAIT.
REQ-021 In WAIT, mem_req=1 and mem_addr/mem_we/mem_wdata SHALL hold the captured values, with rdy=0.
REQ-022 The backend SHALL be allowed to assert mem_ack in the first WAIT cycle at the earliest (minimum added latency of one stall cycle).
REQ-023 On mem_ack in WAIT, the FSM SHALL latch mem_rdata into din for reads, leave din unchanged for writes, drop mem_req, and go to DONE.
REQ-024 DONE SHALL last exactly one cycle with rdy=1 and din valid; the CPU consumes din and presents its next access, which SHALL be captured so that DONE goes straight to WAIT (no idle bubble).
REQ-025 A timeout counter SHALL clear on entry to WAIT and increment each WAIT cycle without ack; on reaching TIMEOUT, din SHALL be set to ERR_DATA (reads only), bus_err SHALL pulse for one cycle, and the FSM SHALL go to DONE.
REQ-026 If mem_ack coincides with the timeout cycle, ack SHALL win: mem_rdata is used and there is no bus_err.
REQ-027 mem_ack outside WAIT SHALL be ignored.
REQ-028 stall_cnt and acc_cnt SHALL increment by 1 per qualifying cycle and wrap from 2^32-1 to 0.
REQ-029 acc_cnt SHALL increment in the cycle the FSM leaves WAIT.
REQ-030 Exactly one access SHALL be outstanding at any time.

Reset
REQ-031 While rst=0, the block SHALL force state=IDLE, rdy=1, din=8'h00, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, bus_err=0, stall_cnt=0, acc_cnt=0 and timeout=0, regardless of clk.
REQ-032 Reset asserted mid-WAIT SHALL abort the access with no bus_err and no count update; a late mem_ack after reset SHALL be ignored.

Structure
REQ-033 The package cpu_bus_pkg SHALL hold the state enum type and the default TIMEOUT and ERR_DATA constants.
REQ-034 The sub-module bus_timeout_cnt (clear, enable, expired flag) SHALL be instantiated once; everything else SHALL be flat.

Verification
REQ-035 Backend acks 1 cycle after mem_req; CPU reads 0x0400 with mem_rdata=0xA9 -> one stall cycle, din=0xA9 with rdy=1 in DONE, acc_cnt=1, stall_cnt=1.
REQ-036 Back-to-back reads of 0x0400, 0x0401 with ack latency 3 -> mem_req re-asserts the cycle after DONE, stall_cnt=6, acc_cnt=2.
REQ-037 Write 0x55 to 0x0200 -> mem_we=1, mem_addr=0x0200, mem_wdata=0x55 held until ack, din unchanged.
REQ-038 TIMEOUT=4, no ack -> bus_err pulse after 4 WAIT cycles, din=0xFF, rdy=1 next cycle; with ack on cycle 4 instead -> no bus_err, din=mem_rdata.
REQ-039 rst=0 asynchronously mid-WAIT, then ack arrives -> outputs at reset values immediately, ack ignored, counters 0.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared types and defaults for the CPU-to-memory bridge.
// Holds the bridge state encoding and the default timeout/error-data values.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } bus_state_e;

  localparam int unsigned DEFAULT_TIMEOUT  = 255;
  localparam logic [7:0]  DEFAULT_ERR_DATA = 8'hFF;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Counts WAIT cycles without an acknowledge and flags the cycle that
// reaches LIMIT, so the bridge can abort a stuck backend access.
module bus_timeout_cnt #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // NOTE: state flops use non-blocking assignments so all flops sample their inputs at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of earlier un-acked WAIT cycles, so LIMIT-1 marks the LIMIT-th one.
  assign expired = enable && (cnt_q == 8'(LIMIT - 1));

endmodule

// File: rtl/cpu_mem_bridge.sv
// Bridges a single-cycle CPU bus to a handshaked memory backend by stalling
// the CPU (rdy=0) while one access is outstanding, with timeout recovery.
module cpu_mem_bridge
  import cpu_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT  = DEFAULT_TIMEOUT,
  parameter logic [7:0]  ERR_DATA = DEFAULT_ERR_DATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ab,
  input  logic        we,
  input  logic [7:0]  dout,
  output logic [7:0]  din,
  output logic        rdy,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        bus_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] acc_cnt
);

  bus_state_e  state_q, state_d;
  logic        rdy_q, rdy_d;
  logic [7:0]  din_q, din_d;
  logic        mem_req_q, mem_req_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] acc_cnt_q, acc_cnt_d;
  logic        tmo_expired;

  // Cleared in every non-WAIT cycle, which is always the cycle before WAIT is entered.
  bus_timeout_cnt #(.LIMIT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst_n  (rst),
    .clear  (state_q != WAIT),
    .enable ((state_q == WAIT) && !mem_ack),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d     = state_q;
    rdy_d       = rdy_q;
    din_d       = din_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    bus_err_d   = 1'b0;
    stall_cnt_d = stall_cnt_q;
    acc_cnt_d   = acc_cnt_q;

    if (!rdy_q) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end

    case (state_q)
      // The CPU presents an access in every ready cycle, so IDLE and DONE both launch one.
      IDLE, DONE: begin
        mem_addr_d  = ab;
        mem_we_d    = we;
        mem_wdata_d = dout;
        mem_req_d   = 1'b1;
        rdy_d       = 1'b0;
        state_d     = WAIT;
      end
      WAIT: begin
        if (mem_ack || tmo_expired) begin
          if (!mem_we_q) begin
            din_d = mem_ack ? mem_rdata : ERR_DATA;
          end
          bus_err_d = !mem_ack;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          rdy_d     = 1'b1;
          acc_cnt_d = acc_cnt_q + 32'd1;
          state_d   = DONE;
        end
      end
      default: begin
        rdy_d     = 1'b1;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b1;
      din_q       <= 8'h00;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= 8'h00;
      bus_err_q   <= 1'b0;
      stall_cnt_q <= 32'd0;
      acc_cnt_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rdy_d;
      din_q       <= din_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      bus_err_q   <= bus_err_d;
      stall_cnt_q <= stall_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
    end
  end

  assign din       = din_q;
  assign rdy       = rdy_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign bus_err   = bus_err_q;
  assign stall_cnt = stall_cnt_q;
  assign acc_cnt   = acc_cnt_q;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// Randomized bench for cpu_mem_bridge: a backend that acks after a chosen
// number of WAIT cycles, checked against an access-level model of the bridge.
module tb_cpu_mem_bridge;

  localparam int         TMO = 4;
  localparam logic [7:0] ERR = 8'hFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ab;
  logic        we;
  logic [7:0]  dout;
  logic [7:0]  din;
  logic        rdy;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        bus_err;
  logic [31:0] stall_cnt;
  logic [31:0] acc_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Access-level model: read data the CPU last saw, total stall cycles, completed accesses.
  logic [7:0]  m_din;
  logic [31:0] m_stall;
  logic [31:0] m_acc;

  cpu_mem_bridge #(.TIMEOUT(TMO), .ERR_DATA(ERR)) dut (
    .clk(clk), .rst(rst), .ab(ab), .we(we), .dout(dout), .din(din), .rdy(rdy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err),
    .stall_cnt(stall_cnt), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a falling edge with the bridge ready (IDLE or DONE). lat is the WAIT cycle
  // in which the backend acks (0 or beyond TMO means never). Returns at the DONE falling edge.
  task automatic do_access(input logic [15:0] a, input logic w, input logic [7:0] wd,
                           input int lat, input logic [7:0] rd, input logic spurious);
    int   waits;
    logic err;
    ab = a; we = w; dout = wd;
    if (lat >= 1 && lat <= TMO) begin
      waits = lat; err = 1'b0;
    end else begin
      waits = TMO; err = 1'b1;
    end
    for (int k = 1; k <= waits; k++) begin
      @(negedge clk);
      n_checks++;
      if ({rdy, mem_req, mem_we, mem_addr, mem_wdata, bus_err} !== {1'b0, 1'b1, w, a, wd, 1'b0}) begin
        $display("FAIL wait[%0d] @%h: got rdy/req/we/addr/wdata/err=%b/%b/%b/%h/%h/%b want 0/1/%b/%h/%h/0",
                 k, a, rdy, mem_req, mem_we, mem_addr, mem_wdata, bus_err, w, a, wd);
      end else n_pass++;
      mem_ack   = (k == lat);
      mem_rdata = (k == lat) ? rd : 8'($urandom);
      ab = 16'($urandom); we = 1'($urandom); dout = 8'($urandom);
    end
    @(negedge clk);
    if (!w) m_din = err ? ERR : rd;
    m_stall = m_stall + 32'(waits);
    m_acc   = m_acc + 32'd1;
    n_checks++;
    if ({rdy, mem_req, bus_err, din, stall_cnt, acc_cnt} !== {1'b1, 1'b0, err, m_din, m_stall, m_acc}) begin
      $display("FAIL done @%h: got rdy/req/err/din/stall/acc=%b/%b/%b/%h/%0d/%0d want 1/0/%b/%h/%0d/%0d",
               a, rdy, mem_req, bus_err, din, stall_cnt, acc_cnt, err, m_din, m_stall, m_acc);
    end else n_pass++;
    mem_ack   = spurious;
    mem_rdata = 8'($urandom);
  endtask

  task automatic check_reset_values(input string name);
    n_checks++;
    if ({rdy, din, mem_req, mem_we, mem_addr, mem_wdata, bus_err, stall_cnt, acc_cnt} !==
        {1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 32'd0, 32'd0}) begin
      $display("FAIL %s: got rdy/din/req/we/addr/wdata/err/stall/acc=%b/%h/%b/%b/%h/%h/%b/%0d/%0d want 1/00/0/0/0000/00/0/0/0",
               name, rdy, din, mem_req, mem_we, mem_addr, mem_wdata, bus_err, stall_cnt, acc_cnt);
    end else n_pass++;
  endtask

  task automatic release_reset();
    m_din = 8'h00; m_stall = 32'd0; m_acc = 32'd0;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; ab = 16'h1234; we = 1'b0; dout = 8'h00; mem_ack = 1'b1; mem_rdata = 8'h5A;
    @(negedge clk);
    check_reset_values("reset_hold");
    @(negedge clk);
    check_reset_values("reset_hold_ack");
    release_reset();
  endtask

  task automatic test_single_read();
    do_access(16'h0400, 1'b0, 8'h00, 1, 8'hA9, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_access(16'h0400, 1'b0, 8'h00, 3, 8'($urandom), 1'b0);
    do_access(16'h0401, 1'b0, 8'h00, 3, 8'($urandom), 1'b0);
  endtask

  task automatic test_write();
    do_access(16'h0200, 1'b1, 8'h55, 2, 8'($urandom), 1'b0);
  endtask

  task automatic test_timeout();
    do_access(16'h0300, 1'b0, 8'h00, 0, 8'h00, 1'b0);
    do_access(16'h0301, 1'b0, 8'h00, TMO, 8'h3C, 1'b0);
    do_access(16'h0302, 1'b1, 8'h77, 0, 8'h00, 1'b0);
    do_access(16'h0303, 1'b0, 8'h00, 1, 8'h11, 1'b0);
  endtask

  task automatic test_spurious_ack();
    do_access(16'h0500, 1'b0, 8'h00, 2, 8'h42, 1'b1);
    do_access(16'h0501, 1'b0, 8'h00, 3, 8'h24, 1'b1);
    do_access(16'h0502, 1'b1, 8'h99, 1, 8'h66, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      do_access(16'($urandom), 1'($urandom), 8'($urandom), int'($urandom_range(0, TMO + 2)),
                8'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_wait();
    ab = 16'h0600; we = 1'b0; dout = 8'h00; mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_values("reset_async_mid_wait");
    mem_ack = 1'b1; mem_rdata = 8'hC3;
    @(negedge clk);
    check_reset_values("reset_late_ack");
    release_reset();
    do_access(16'h0601, 1'b0, 8'h00, 0, 8'h00, 1'b0);
    do_access(16'h0602, 1'b0, 8'h00, 2, 8'h5E, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_write();
    test_timeout();
    test_spurious_ack();
    test_random();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
